fill_rect: RTL and testbench
============================

Name: fill_rect

Overview:
- Parametrised rectangle rasteriser for the VGA adapter. It draws a rectangle of any position and size in one colour, in either solid or outline mode.
- Sits between the game-master FSM and the VGA adapter plot interface, alongside the full-screen filler.
- Emits one pixel per clock with no idle cycles between pixels. Handshake is start/done.

Parameters:
- X_W, 9, width of x coordinate and rectangle width bus
- Y_W, 8, width of y coordinate and rectangle height bus
- COLOUR_W, 3, colour width
- SCREEN_W, 160, visible columns (x valid range 0..SCREEN_W-1)
- SCREEN_H, 120, visible rows (y valid range 0..SCREEN_H-1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- x0  in  X_W  left column
- y0  in  Y_W  top row
- w  in  X_W  width in pixels
- h  in  Y_W  height in pixels
- colour  in  COLOUR_W  draw colour
- outline  in  1  0 = solid fill, 1 = 1-pixel border only
- busy  out  1  high in RUN
- done  out  1  high in DONE
- vga_x  out  X_W  pixel column
- vga_y  out  Y_W  pixel row
- vga_colour  out  COLOUR_W  pixel colour
- vga_plot  out  1  pixel write strobe

Behaviour:
- One clock domain. rst is synchronous and active-high.
- Reset takes effect on the next clk edge, including mid-draw. After reset: state IDLE, busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, internal counters=0.
- Register all outputs.
- States:
  - IDLE: if start=1, latch x0, y0, w, h, colour and outline, and clear counters i (column offset) and j (row offset). If w=0 or h=0, go to DONE; otherwise go to RUN.
  - RUN: each cycle, present pixel (x0+i, y0+j). Scan order is column-major: j increments first. When j=h-1, j wraps to 0 and i increments. After i=w-1 and j=h-1, go to DONE.
  - DONE: done=1 and vga_plot=0. Stay in DONE while start=1; go to IDLE when start=0.
- Latched inputs are frozen for the whole draw. Input changes while busy are ignored. start asserted outside IDLE is ignored.
- Latency and throughput:
  - start sampled on edge N gives the first pixel on the outputs after edge N+1.
  - Exactly w*h RUN cycles per draw.
  - done rises on the edge after the last pixel.
  - w=0 or h=0 gives done one cycle after start, with zero plots.
- vga_plot=1 in RUN only when the pixel is drawable:
  - outline=0: every scanned pixel is drawable.
  - outline=1: a pixel is drawable only when i=0, i=w-1, j=0 or j=h-1. Interior pixels still consume a cycle with vga_plot=0.
- Arithmetic:
  - Compute x0+i in X_W+1 bits and y0+j in Y_W+1 bits.
  - vga_x/vga_y carry the low X_W/Y_W bits.
  - i and j are X_W/Y_W bits wide and never exceed w-1/h-1.
- Single-row and single-column rectangles (h=1 or w=1) are entirely border; every pixel plots in both modes.
- vga_colour equals the latched colour whenever state is RUN.

Optional Feature:
- Macro FILL_RECT_CLIP_EN.
- Defined: vga_plot is additionally forced to 0 when the full-width x0+i >= SCREEN_W or y0+j >= SCREEN_H. Cycle count is unchanged.
- Not defined: no clipping. Off-screen pixels plot with truncated coordinates, and the adapter is responsible for discarding them.

Test Plan:
- Solid draw: reset, then start with x0=10, y0=20, w=3, h=2, colour=5, outline=0.
  - Required: 6 plots, in order (10,20), (10,21), (11,20), (11,21), (12,20), (12,21), all with colour 5.
  - done rises 1 cycle after the last plot; busy is high for exactly 6 cycles.
- Outline draw: w=4, h=4, outline=1.
  - Required: 16 RUN cycles and 12 plots; (x0+1,y0+1), (x0+1,y0+2), (x0+2,y0+1) and (x0+2,y0+2) are not plotted.
- Zero size: w=0, h=5.
  - Required: no vga_plot, done=1 one cycle after start; done held while start=1; IDLE once start drops.
- Degenerate shapes: w=1, h=1 with outline=1 gives exactly 1 plot. w=5, h=1 with outline=1 gives 5 plots.
- Reset mid-draw: assert rst during the 3rd pixel of a 4x4 draw.
  - Required: the next cycle has all outputs 0 in IDLE; a new start then runs to completion with 16 plots.
- Clipping, with FILL_RECT_CLIP_EN defined: x0=158, y0=118, w=4, h=4.
  - Required: 16 RUN cycles; plots only at x in {158,159} and y in {118,119}, i.e. 4 plots.
  - With the macro undefined, the same stimulus gives 16 plots.

Source files
------------

// File: rtl/fill_rect.sv
// fill_rect: column-major rectangle rasteriser, one pixel per clock; define FILL_RECT_CLIP_EN to suppress off-screen plots
module fill_rect #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                outline,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [X_W-1:0] x_r, w_r, i, x_d;
  logic [Y_W-1:0] y_r, h_r, j, y_d;
  logic [COLOUR_W-1:0] c_r, c_d;
  logic o_r, i_end, j_end, last, edge_px, draw, busy_d, done_d, plot_d;
  logic [X_W:0] sx;
  logic [Y_W:0] sy;
  assign sx      = {1'b0, x_r} + {1'b0, i};
  assign sy      = {1'b0, y_r} + {1'b0, j};
  assign i_end   = i == w_r - X_W'(1);
  assign j_end   = j == h_r - Y_W'(1);
  assign last    = i_end && j_end;
  assign edge_px = i == '0 || i_end || j == '0 || j_end;
`ifdef FILL_RECT_CLIP_EN
  assign draw = (!o_r || edge_px) && sx < (X_W+1)'(SCREEN_W) && sy < (Y_W+1)'(SCREEN_H);
`else
  assign draw = !o_r || edge_px;
`endif
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state: empty rectangles skip straight to DONE
  always_comb
    state_n = state == IDLE ? (start ? ((w == '0 || h == '0) ? DONE : RUN) : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (start ? DONE : IDLE);
  // next output values; pixel fields hold outside RUN
  always_comb begin
    busy_d = state == RUN;
    done_d = state == DONE;
    plot_d = state == RUN && draw;
    x_d    = state == RUN ? sx[X_W-1:0] : vga_x;
    y_d    = state == RUN ? sy[Y_W-1:0] : vga_y;
    c_d    = state == RUN ? c_r : vga_colour;
  end
  // output register, one cycle behind the scan counters
  always_ff @(posedge clk)
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      vga_plot   <= plot_d;
      vga_x      <= x_d;
      vga_y      <= y_d;
      vga_colour <= c_d;
    end
  // request latch and column-major scan counters (j fastest)
  always_ff @(posedge clk)
    if (rst) begin
      x_r <= '0;
      y_r <= '0;
      w_r <= '0;
      h_r <= '0;
      c_r <= '0;
      o_r <= 1'b0;
      i   <= '0;
      j   <= '0;
    end else if (state == IDLE && start) begin
      x_r <= x0;
      y_r <= y0;
      w_r <= w;
      h_r <= h;
      c_r <= colour;
      o_r <= outline;
      i   <= '0;
      j   <= '0;
    end else if (state == RUN && !last) begin
      j <= j_end ? '0 : j + Y_W'(1);
      i <= j_end ? i + X_W'(1) : i;
    end
endmodule

// File: tb/tb_fill_rect.sv
// tb_fill_rect: randomized and directed draws checked against a nested-loop pixel model
module tb_fill_rect;
  logic clk = 0, rst = 1, start = 0, outline = 0;
  logic [8:0] x0 = 0, w = 0, vga_x;
  logic [7:0] y0 = 0, h = 0, vga_y;
  logic [2:0] colour = 0, vga_colour;
  logic busy, done, vga_plot;
  int errors = 0, checks = 0;

  fill_rect dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .colour(colour), .outline(outline), .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    x0 = 9'($urandom); y0 = 8'($urandom); w = 9'($urandom); h = 8'($urandom);
    colour = 3'($urandom); outline = 1'($urandom);
  endtask

  task automatic draw(input int x, input int y, input int ww, input int hh,
                      input int c, input int o, input bit hold);
    logic [31:0] exp_q[$];
    int k, run_n, plot_n;
    bit on;
    for (int a = 0; a < ww; a++)
      for (int b = 0; b < hh; b++) begin
        on = !o || a == 0 || a == ww - 1 || b == 0 || b == hh - 1;
`ifdef FILL_RECT_CLIP_EN
        on = on && x + a < 160 && y + b < 120;
`endif
        if (on) exp_q.push_back({12'd0, 3'(c), 8'((y + b) % 256), 9'((x + a) % 512)});
      end
    @(negedge clk);
    x0 = 9'(x); y0 = 8'(y); w = 9'(ww); h = 8'(hh); colour = 3'(c); outline = 1'(o); start = 1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 0;
    scramble();
    k = 0; run_n = 0; plot_n = 0;
    while (k < 300) begin
      @(negedge clk);
      k++;
      if (busy) run_n++;
      if (vga_plot) begin
        if (plot_n < exp_q.size())
          check("pixel", {12'd0, vga_colour, vga_y, vga_x}, exp_q[plot_n]);
        plot_n++;
      end
      if (done) break;
      scramble();
    end
    check("done_latency", k, ww * hh + 1);
    check("run_cycles", run_n, ww * hh);
    check("plot_count", plot_n, exp_q.size());
    if (hold) begin
      repeat (3) @(negedge clk);
      check("done_held", done, 1);
      start = 0;
    end
    repeat (2) @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_outputs", {busy, done, vga_plot, vga_x, vga_y, vga_colour}, 0);
    rst = 0;
    draw(10, 20, 3, 2, 5, 0, 0);
    draw(30, 40, 4, 4, 2, 1, 0);
    draw(50, 60, 0, 5, 7, 0, 1);
    draw(70, 80, 1, 1, 3, 1, 0);
    draw(90, 30, 5, 1, 6, 1, 0);
    draw(158, 118, 4, 4, 4, 0, 0);
    draw(158, 118, 4, 4, 1, 1, 0);
    @(negedge clk);
    x0 = 20; y0 = 20; w = 4; h = 4; colour = 1; outline = 0; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_mid_outputs", {busy, done, vga_plot, vga_x, vga_y, vga_colour}, 0);
    repeat (2) @(negedge clk);
    check("rst_mid_idle", {busy, done, vga_plot}, 0);
    draw(20, 20, 4, 4, 1, 0, 0);
    for (int n = 0; n < 40; n++)
      draw($urandom_range(0, 170), $urandom_range(0, 130), $urandom_range(0, 8),
           $urandom_range(0, 8), $urandom_range(0, 7), $urandom_range(0, 1), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
